// File: rtl/ioctl_pkg.sv
// Shared types and constants for the HPS ioctl upload server.
package ioctl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_READ,
    ST_HOLD
  } state_t;

  localparam logic [7:0] UPLOAD_INDEX_DEFAULT = 8'd4;
  localparam logic [7:0] OOR_BYTE             = 8'hFF;

endpackage

// File: rtl/ioctl_upload_server.sv
// Serves HPS upload reads (hiscore/NVRAM save) from a core-side buffer behind a
// request/grant read port with fixed read latency.
module ioctl_upload_server
  import ioctl_pkg::*;
#(
  parameter logic [7:0] UPLOAD_INDEX = UPLOAD_INDEX_DEFAULT,
  parameter int         ADDR_W       = 10,
  parameter int         RD_LATENCY   = 1
) (
  input  logic              clk_sys,
  input  logic              reset,
  input  logic              ioctl_upload,
  input  logic [7:0]        ioctl_index,
  input  logic              ioctl_rd,
  input  logic [24:0]       ioctl_addr,
  output logic [7:0]        ioctl_din,
  output logic              ioctl_wait,
  output logic              ram_req,
  input  logic              ram_gnt,
  output logic [ADDR_W-1:0] ram_addr,
  input  logic [7:0]        ram_dout,
  output logic              upload_done,
  output logic              proto_err
);

  state_t            state, state_nxt;
  logic [1:0]        cnt, cnt_nxt;
  logic [7:0]        din_nxt;
  logic              wait_nxt, req_nxt;
  logic [ADDR_W-1:0] addr_nxt;
  logic              served, served_nxt;
  logic              done_nxt, err_nxt;
  logic              upload_prev;
  logic              rd_hit, in_range, upload_fall;

  assign rd_hit      = ioctl_rd & ioctl_upload & (ioctl_index == UPLOAD_INDEX);
  // Range check on the full address so high bits never alias into the buffer.
  assign in_range    = (ioctl_addr >> ADDR_W) == 25'd0;
  assign upload_fall = upload_prev & ~ioctl_upload;

  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    din_nxt    = ioctl_din;
    wait_nxt   = ioctl_wait;
    req_nxt    = ram_req;
    addr_nxt   = ram_addr;
    served_nxt = served;
    done_nxt   = 1'b0;
    err_nxt    = proto_err;

    if (upload_fall) begin
      done_nxt   = served;
      served_nxt = 1'b0;
    end

    if (state != ST_IDLE && ioctl_rd) err_nxt = 1'b1;

    // Session teardown wins over any fetch in flight; ioctl_din is left alone.
    if (state != ST_IDLE && !ioctl_upload) begin
      state_nxt = ST_IDLE;
      wait_nxt  = 1'b0;
      req_nxt   = 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (rd_hit) begin
            if (in_range) begin
              addr_nxt   = ioctl_addr[ADDR_W-1:0];
              wait_nxt   = 1'b1;
              req_nxt    = 1'b1;
              served_nxt = 1'b1;
              state_nxt  = ST_REQ;
            end else begin
              din_nxt = OOR_BYTE;
            end
          end
        end
        ST_REQ: begin
          if (ram_gnt) begin
            req_nxt   = 1'b0;
            cnt_nxt   = 2'(RD_LATENCY);
            state_nxt = ST_READ;
          end
        end
        ST_READ: begin
          cnt_nxt = cnt - 2'd1;
          if (cnt == 2'd1) begin
            din_nxt   = ram_dout;
            state_nxt = ST_HOLD;
          end
        end
        ST_HOLD: begin
          wait_nxt  = 1'b0;
          state_nxt = ST_IDLE;
        end
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      state       <= ST_IDLE;
      cnt         <= 2'd0;
      ioctl_din   <= 8'h00;
      ioctl_wait  <= 1'b0;
      ram_req     <= 1'b0;
      ram_addr    <= '0;
      served      <= 1'b0;
      upload_done <= 1'b0;
      proto_err   <= 1'b0;
      upload_prev <= 1'b0;
    end else begin
      state       <= state_nxt;
      cnt         <= cnt_nxt;
      ioctl_din   <= din_nxt;
      ioctl_wait  <= wait_nxt;
      ram_req     <= req_nxt;
      ram_addr    <= addr_nxt;
      served      <= served_nxt;
      upload_done <= done_nxt;
      proto_err   <= err_nxt;
      upload_prev <= ioctl_upload;
    end
  end

endmodule
